// File: rtl/mips_run_ctrl_pkg.sv
// Shared definitions for the mips run controller: FSM encodings and default
// program-end / timeout settings.
package mips_run_ctrl_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE     = 3'd0;
  localparam state_t ST_RST_HOLD = 3'd1;
  localparam state_t ST_RUN      = 3'd2;
  localparam state_t ST_DONE     = 3'd3;
  localparam state_t ST_TMO      = 3'd4;

  localparam logic [31:0]     DEF_HALT_INSTR = 32'h0000_000C;
  localparam longint unsigned DEF_TIMEOUT    = 64'd100000;

endpackage

// File: rtl/mips_run_ctrl_halt_detect.sv
// Program-end detector: fires on the halt opcode or when the PC has compared
// equal to its previous value HALT_REPEAT times in a row.
module halt_detect
  import mips_run_ctrl_pkg::*;
#(
  parameter int          PC_W        = 32,
  parameter logic [31:0] HALT_INSTR  = DEF_HALT_INSTR,
  parameter int          HALT_REPEAT = 3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clr,
  input  logic            en,
  input  logic [PC_W-1:0] pc_i,
  input  logic [31:0]     instr_i,
  output logic            halt
);

  localparam int             SW          = $clog2(HALT_REPEAT + 1);
  localparam logic [SW-1:0]  STABLE_LAST = SW'(HALT_REPEAT - 1);
  localparam logic [SW-1:0]  STABLE_MAX  = SW'(HALT_REPEAT);

  logic [PC_W-1:0] prev_pc;
  logic            pc_vld;
  logic [SW-1:0]   stable_cnt;
  logic            same_pc;

  // The first RUN cycle only captures the PC; no compare is possible yet.
  assign same_pc = pc_vld && (pc_i == prev_pc);
  assign halt    = en && ((instr_i == HALT_INSTR) ||
                          (same_pc && (stable_cnt == STABLE_LAST)));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_pc    <= '0;
      pc_vld     <= 1'b0;
      stable_cnt <= '0;
    end else if (clr) begin
      prev_pc    <= '0;
      pc_vld     <= 1'b0;
      stable_cnt <= '0;
    end else if (en) begin
      prev_pc <= pc_i;
      pc_vld  <= 1'b1;
      if (!same_pc)
        stable_cnt <= '0;
      else if (stable_cnt != STABLE_MAX)
        stable_cnt <= stable_cnt + SW'(1);
    end
  end

endmodule

// File: rtl/mips_run_ctrl.sv
// Run controller for the mips core: stretched core reset, RUN cycle counting,
// halt / timeout detection and restart from DONE or TMO without global reset.
module mips_run_ctrl
  import mips_run_ctrl_pkg::*;
#(
  parameter int              RST_CYCLES  = 4,
  parameter int              PC_W        = 32,
  parameter int              CNT_W       = 32,
  parameter longint unsigned TIMEOUT     = DEF_TIMEOUT,
  parameter logic [31:0]     HALT_INSTR  = DEF_HALT_INSTR,
  parameter int              HALT_REPEAT = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [PC_W-1:0]  pc_i,
  input  logic [31:0]      instr_i,
  output logic             core_reset_o,
  output logic             running_o,
  output logic             done_o,
  output logic             timeout_o,
  output logic [CNT_W-1:0] cycle_cnt_o
);

  localparam int              HW          = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [HW-1:0]   HOLD_LOAD   = HW'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST   = CNT_W'(TIMEOUT - 64'd1);
  localparam longint unsigned MAX_TIMEOUT = (CNT_W >= 64) ? '1 : (64'd1 << CNT_W);

  state_t        state;
  logic [HW-1:0] hold_cnt;
  logic          halt;
  logic          tmo_hit;
  logic          hd_clr;
  logic          hd_en;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  assign hd_en   = (state == ST_RUN);
  assign hd_clr  = start && ((state == ST_IDLE) || (state == ST_DONE) || (state == ST_TMO));
  assign tmo_hit = (TIMEOUT != 64'd0) && (cycle_cnt_o == TMO_LAST);

  halt_detect #(
    .PC_W        (PC_W),
    .HALT_INSTR  (HALT_INSTR),
    .HALT_REPEAT (HALT_REPEAT)
  ) u_halt_detect (
    .clk     (clk),
    .reset   (reset),
    .clr     (hd_clr),
    .en      (hd_en),
    .pc_i    (pc_i),
    .instr_i (instr_i),
    .halt    (halt)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      hold_cnt     <= '0;
      core_reset_o <= 1'b1;
      running_o    <= 1'b0;
      done_o       <= 1'b0;
      timeout_o    <= 1'b0;
      cycle_cnt_o  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state    <= ST_RST_HOLD;
            hold_cnt <= HOLD_LOAD;
          end
        end
        ST_RST_HOLD: begin
          if (hold_cnt == '0) begin
            state        <= ST_RUN;
            core_reset_o <= 1'b0;
            running_o    <= 1'b1;
            cycle_cnt_o  <= '0;
          end else begin
            hold_cnt <= hold_cnt - HW'(1);
          end
        end
        ST_RUN: begin
          // Halt outranks timeout; the timeout edge itself is not counted.
          if (halt) begin
            state       <= ST_DONE;
            done_o      <= 1'b1;
            running_o   <= 1'b0;
            cycle_cnt_o <= sat_inc(cycle_cnt_o);
          end else if (tmo_hit) begin
            state     <= ST_TMO;
            timeout_o <= 1'b1;
            running_o <= 1'b0;
          end else begin
            cycle_cnt_o <= sat_inc(cycle_cnt_o);
          end
        end
        ST_DONE, ST_TMO: begin
          if (start) begin
            state        <= ST_RST_HOLD;
            hold_cnt     <= HOLD_LOAD;
            core_reset_o <= 1'b1;
            done_o       <= 1'b0;
            timeout_o    <= 1'b0;
            cycle_cnt_o  <= '0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  a_timeout_range: assert property (@(posedge clk) TIMEOUT <= MAX_TIMEOUT)
    else $error("mips_run_ctrl: TIMEOUT exceeds 2**CNT_W");

endmodule

// File: tb/tb_mips_run_ctrl.sv
// Bench for mips_run_ctrl: directed vector table, async-reset sequence and
// randomized stimulus against a queue-based reference model.
module tb_mips_run_ctrl;

  localparam int          RST_CYCLES  = 4;
  localparam int          TIMEOUT     = 10;
  localparam int          HALT_REPEAT = 3;
  localparam logic [31:0] HALT        = 32'h0000_000C;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [31:0] pc = '0;
  logic [31:0] instr = '0;
  logic        core_reset_o, running_o, done_o, timeout_o;
  logic [15:0] cycle_cnt_o;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  mips_run_ctrl #(
    .RST_CYCLES  (RST_CYCLES),
    .PC_W        (32),
    .CNT_W       (16),
    .TIMEOUT     (TIMEOUT),
    .HALT_INSTR  (HALT),
    .HALT_REPEAT (HALT_REPEAT)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .pc_i         (pc),
    .instr_i      (instr),
    .core_reset_o (core_reset_o),
    .running_o    (running_o),
    .done_o       (done_o),
    .timeout_o    (timeout_o),
    .cycle_cnt_o  (cycle_cnt_o)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else passed++;
  endtask

  task automatic chk_all(input string tag, input logic cr, input logic run,
                         input logic dn, input logic to, input int cnt);
    chk({tag, " core_reset"}, core_reset_o, cr);
    chk({tag, " running"},    running_o,    run);
    chk({tag, " done"},       done_o,       dn);
    chk({tag, " timeout"},    timeout_o,    to);
    chk({tag, " cycle_cnt"},  cycle_cnt_o,  cnt);
  endtask

  typedef struct {
    logic        start;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        cr, run, dn, to;
    int          cnt;
  } vec_t;
  vec_t vecs[$];

  function automatic void add(logic s, logic [31:0] p, logic [31:0] ins,
                              logic cr, logic run, logic dn, logic to, int cnt);
    vec_t v;
    v.start = s; v.pc = p; v.instr = ins;
    v.cr = cr; v.run = run; v.dn = dn; v.to = to; v.cnt = cnt;
    vecs.push_back(v);
  endfunction

  function automatic void add_start_hold();
    add(1, 0, 0, 1, 0, 0, 0, 0);
    for (int i = 0; i < RST_CYCLES - 1; i++) add(0, 0, 0, 1, 0, 0, 0, 0);
    add(0, 0, 0, 0, 1, 0, 0, 0);
  endfunction

  // Reference model: phases, edges since start, and a history of RUN PCs.
  typedef enum {M_IDLE, M_HOLD, M_RUN, M_DONE, M_TMO} mphase_e;
  mphase_e     mph = M_IDLE;
  int          hold_edges = 0;
  int          mcnt = 0;
  logic [31:0] hist[$];

  function automatic int tail_len(logic [31:0] p);
    int n = 0;
    for (int i = hist.size() - 1; i >= 0; i--) begin
      if (hist[i] != p) break;
      n++;
    end
    return n;
  endfunction

  task automatic model_edge(input logic s, input logic [31:0] p, input logic [31:0] ins);
    bit h, t;
    case (mph)
      M_HOLD: begin
        hold_edges++;
        if (hold_edges == RST_CYCLES) begin
          mph = M_RUN; mcnt = 0; hist.delete();
        end
      end
      M_RUN: begin
        h = (ins == HALT) || (tail_len(p) >= HALT_REPEAT);
        t = (mcnt == TIMEOUT - 1);
        hist.push_back(p);
        if (h) begin mph = M_DONE; mcnt++; end
        else if (t) mph = M_TMO;
        else mcnt++;
      end
      default: if (s) begin mph = M_HOLD; hold_edges = 0; mcnt = 0; end
    endcase
  endtask

  initial begin
    // Run 1: reset stretch then halt by opcode.
    add_start_hold();
    add(0, 32'h3000, 0, 0, 1, 0, 0, 1);
    add(0, 32'h3004, 0, 0, 1, 0, 0, 2);
    add(0, 32'h3008, 0, 0, 1, 0, 0, 3);
    add(0, 32'h300C, HALT, 0, 0, 1, 0, 4);
    add(0, 32'h300C, 0, 0, 0, 1, 0, 4);
    // Run 2: start inside RUN ignored; stuck PC with an interrupting change.
    add_start_hold();
    add(1, 32'h300C, 0, 0, 1, 0, 0, 1);
    add(0, 32'h300C, 0, 0, 1, 0, 0, 2);
    add(0, 32'h300C, 0, 0, 1, 0, 0, 3);
    add(0, 32'h3010, 0, 0, 1, 0, 0, 4);
    add(0, 32'h300C, 0, 0, 1, 0, 0, 5);
    add(0, 32'h300C, 0, 0, 1, 0, 0, 6);
    add(0, 32'h300C, 0, 0, 1, 0, 0, 7);
    add(0, 32'h300C, 0, 0, 0, 1, 0, 8);
    // Run 3: timeout.
    add_start_hold();
    for (int i = 0; i < TIMEOUT - 1; i++) add(0, 32'h200 + 4 * i, 0, 0, 1, 0, 0, i + 1);
    add(0, 32'h224, 0, 0, 0, 0, 1, 9);
    add(0, 32'h228, 0, 0, 0, 0, 1, 9);
    // Run 4: halt and timeout on the same edge.
    add_start_hold();
    for (int i = 0; i < TIMEOUT - 1; i++) add(0, 32'h200 + 4 * i, 0, 0, 1, 0, 0, i + 1);
    add(0, 32'h224, HALT, 0, 0, 1, 0, 10);

    #12;
    chk_all("reset", 1, 0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk_all("idle", 1, 0, 0, 0, 0);

    foreach (vecs[i]) begin
      start = vecs[i].start; pc = vecs[i].pc; instr = vecs[i].instr;
      @(negedge clk);
      chk_all($sformatf("vec%0d", i), vecs[i].cr, vecs[i].run, vecs[i].dn, vecs[i].to, vecs[i].cnt);
    end

    // Async reset in the middle of RUN.
    start = 1'b1; instr = '0; pc = 32'h400;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < RST_CYCLES + 1; i++) begin
      pc = pc + 4;
      @(negedge clk);
    end
    chk_all("prerst", 0, 1, 0, 0, 1);
    #2 reset = 1'b1;
    #1 chk_all("midrst", 1, 0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk_all("postrst", 1, 0, 0, 0, 0);

    // Randomized traffic against the model.
    mph = M_IDLE; mcnt = 0; hist.delete();
    for (int c = 0; c < 3000; c++) begin
      start = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 1) == 1) pc = 32'h3000 + ($urandom_range(0, 3) << 2);
      instr = ($urandom_range(0, 15) == 0) ? HALT : $urandom;
      model_edge(start, pc, instr);
      @(negedge clk);
      chk_all($sformatf("rnd%0d", c), (mph == M_IDLE) || (mph == M_HOLD), mph == M_RUN,
              mph == M_DONE, mph == M_TMO, mcnt);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
